// File: rtl/pixel_framebuffer_port_pkg.sv
// Shared definitions for the pixel framebuffer port and the draw engines.
// Holds the LCD geometry, the framebuffer address width, the port FSM
// encoding and a small saturating-counter helper.
package pixel_fb_pkg;

    localparam int LCD_WIDTH     = 240;
    localparam int LCD_HEIGHT    = 320;
    localparam int FB_PIXELS     = LCD_WIDTH * LCD_HEIGHT;
    localparam int FB_ADDR_WIDTH = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } fbState_e;

    // Adds one to an 8-bit count, sticking at 255 instead of wrapping.
    function automatic logic [7:0] satIncrement(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/pixel_framebuffer_port_if.sv
// Pixel-write handshake plus shadow-memory write bus.
// The slave modport is the framebuffer port itself; the master modport is the
// side that drives pixels and models the memory (drawing engine + RAM).
interface pixel_framebuffer_port_if
    import pixel_fb_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) ();

    logic [7:0]            xAddr;
    logic [8:0]            yAddr;
    logic [15:0]           pixelData;
    logic                  pixelWrite;
    logic                  pixelReady;

    logic [ADDR_WIDTH-1:0] memAddr;
    logic [15:0]           memWriteData;
    logic                  memWrite;
    logic                  memWaitRequest;

    modport slave (
        input  xAddr,
        input  yAddr,
        input  pixelData,
        input  pixelWrite,
        output pixelReady,
        output memAddr,
        output memWriteData,
        output memWrite,
        input  memWaitRequest
    );

    modport master (
        output xAddr,
        output yAddr,
        output pixelData,
        output pixelWrite,
        input  pixelReady,
        input  memAddr,
        input  memWriteData,
        input  memWrite,
        output memWaitRequest
    );

endinterface

// File: rtl/pixel_framebuffer_port_addr_calc.sv
// pixel_addr_calc: combinational range check and linear address y*WIDTH + x.
// The multiply is unrolled into a sum of constant shifts of y, one per set
// bit of WIDTH (for 240 that is y<<7 + y<<6 + y<<5 + y<<4 = (y<<8)-(y<<4)).
// The sum is carried in ADDR_WIDTH+1 bits so it never wraps.
module pixel_addr_calc
    import pixel_fb_pkg::*;
#(
    parameter int WIDTH      = LCD_WIDTH,
    parameter int HEIGHT     = LCD_HEIGHT,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
    input  logic [7:0]          xAddr,
    input  logic [8:0]          yAddr,
    output logic                inRange,
    output logic [ADDR_WIDTH:0] linearAddr
);

    localparam int          CALC_WIDTH = ADDR_WIDTH + 1;
    localparam logic [31:0] WIDTH_U    = 32'(WIDTH);
    localparam logic [31:0] HEIGHT_U   = 32'(HEIGHT);

    logic [CALC_WIDTH-1:0] yExt;
    logic [CALC_WIDTH-1:0] addrSum;

    // Shift-add of y by the constant width, then add x.
    always_comb begin
        yExt    = CALC_WIDTH'(yAddr);
        addrSum = CALC_WIDTH'(xAddr);
        for (int i = 0; i < CALC_WIDTH; i++) begin
            if (WIDTH_U[i]) begin
                addrSum = addrSum + (yExt << i);
            end
        end
        linearAddr = addrSum;
    end

    assign inRange = ({24'd0, xAddr} < WIDTH_U) && ({23'd0, yAddr} < HEIGHT_U);

endmodule

// File: rtl/pixel_framebuffer_port.sv
// pixel_framebuffer_port: responder for the LCD pixel-write handshake that
// commits each in-range pixel into a single-port shadow framebuffer RAM.
// Out-of-range pixels are dropped with a pulse and a saturating count.
// Optional full-frame clear engine is built when PIXEL_FB_CLEAR_EN is defined.
module pixel_framebuffer_port
    import pixel_fb_pkg::*;
#(
    parameter int WIDTH      = LCD_WIDTH,
    parameter int HEIGHT     = LCD_HEIGHT,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    pixel_framebuffer_port_if.slave  fbBus,
    input  logic                     clearRequest,
    input  logic [15:0]              clearColour,
    output logic                     busy,
    output logic                     pixelError,
    output logic [7:0]               dropCount
);

    fbState_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [15:0]           memWriteData_q, memWriteData_d;
    logic                  pixelError_q, pixelError_d;
    logic [7:0]            dropCount_q, dropCount_d;

    logic                  transfer;
    logic                  writeAccepted;
    logic                  inRange;
    logic [ADDR_WIDTH:0]   linearAddr;
    logic                  unusedAddrMsb;

    pixel_addr_calc #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) addrCalc (
        .xAddr      (fbBus.xAddr),
        .yAddr      (fbBus.yAddr),
        .inRange    (inRange),
        .linearAddr (linearAddr)
    );

    // In-range addresses always fit ADDR_WIDTH bits; the carry bit is spare.
    assign unusedAddrMsb = linearAddr[ADDR_WIDTH];

    // Requests are only accepted in IDLE, so ready is simply "state is IDLE".
    assign transfer      = fbBus.pixelWrite && (state_q == IDLE);
    assign writeAccepted = !fbBus.memWaitRequest;

`ifdef PIXEL_FB_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

    logic        clearPending_q, clearPending_d;
    logic [15:0] clearColour_q, clearColour_d;
    logic        clearDone;

    assign clearDone = (state_q == CLEAR) && writeAccepted && (memAddr_q == LAST_ADDR);

    // A clear pulse arms the fill and latches its colour; the fill's last write disarms it.
    always_comb begin
        clearPending_d = clearPending_q;
        clearColour_d  = clearColour_q;
        if (clearRequest) begin
            clearPending_d = 1'b1;
            clearColour_d  = clearColour;
        end
        if (clearDone) begin
            clearPending_d = 1'b0;
        end
    end

    // Clear request latch registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clearPending_q <= 1'b0;
            clearColour_q  <= 16'h0000;
        end else begin
            clearPending_q <= clearPending_d;
            clearColour_q  <= clearColour_d;
        end
    end
`else
    logic unusedClearInputs;
    assign unusedClearInputs = clearRequest ^ (^clearColour);
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a pixel transfer beats a pending clear in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (inRange) begin
                        state_d = WRITE;
                    end
`ifdef PIXEL_FB_CLEAR_EN
                end else if (clearPending_q) begin
                    state_d = CLEAR;
`endif
                end
            end
            WRITE: begin
                if (writeAccepted) begin
                    state_d = IDLE;
                end
            end
`ifdef PIXEL_FB_CLEAR_EN
            CLEAR: begin
                if (clearDone) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: memory strobe and busy whenever a write is outstanding.
    always_comb begin
        fbBus.pixelReady = (state_q == IDLE);
        fbBus.memWrite   = (state_q != IDLE);
        busy             = (state_q != IDLE);
    end

    // Datapath next values: latch the pixel, count drops, walk the clear address.
    always_comb begin
        memAddr_d      = memAddr_q;
        memWriteData_d = memWriteData_q;
        pixelError_d   = 1'b0;
        dropCount_d    = dropCount_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    if (inRange) begin
                        memAddr_d      = linearAddr[ADDR_WIDTH-1:0];
                        memWriteData_d = fbBus.pixelData;
                    end else begin
                        pixelError_d = 1'b1;
                        dropCount_d  = satIncrement(dropCount_q);
                    end
`ifdef PIXEL_FB_CLEAR_EN
                end else if (clearPending_q) begin
                    memAddr_d      = '0;
                    memWriteData_d = clearColour_q;
`endif
                end
            end
`ifdef PIXEL_FB_CLEAR_EN
            CLEAR: begin
                if (writeAccepted && (memAddr_q != LAST_ADDR)) begin
                    memAddr_d = memAddr_q + 1'b1;
                end
            end
`endif
            default: begin
                memAddr_d = memAddr_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            memAddr_q      <= '0;
            memWriteData_q <= 16'h0000;
            pixelError_q   <= 1'b0;
            dropCount_q    <= 8'd0;
        end else begin
            memAddr_q      <= memAddr_d;
            memWriteData_q <= memWriteData_d;
            pixelError_q   <= pixelError_d;
            dropCount_q    <= dropCount_d;
        end
    end

    assign fbBus.memAddr      = memAddr_q;
    assign fbBus.memWriteData = memWriteData_q;
    assign pixelError         = pixelError_q;
    assign dropCount          = dropCount_q;

endmodule
